// File: rtl/bmu_pkg.sv
// Shared constants and helpers for the Viterbi branch-metric unit.
// Metric width and codeword-bit lookup are evaluated at elaboration time.
package bmu_pkg;

  localparam int N_OUT_MIN  = 2;
  localparam int N_OUT_MAX  = 4;
  localparam int SOFT_W_MIN = 1;
  localparam int SOFT_W_MAX = 4;

  // Widest per-bit distance any legal configuration can produce.
  typedef logic [SOFT_W_MAX-1:0] dist_max_t;

  // Width needed to hold N_OUT fully-disagreeing samples without overflow.
  function automatic int bm_width(input int n_out, input int soft_w);
    return $clog2(n_out * ((1 << soft_w) - 1) + 1);
  endfunction

  // Expected value of code bit k within codeword index c.
  function automatic logic cw_bit(input int c, input int k);
    return ((c >> k) & 1) != 0;
  endfunction

endpackage

// File: rtl/bit_distance.sv
// Distance between one received sample and one expected code bit.
// Offset-binary samples: 0 is a confident '0', all-ones a confident '1'.
module bit_distance #(
  parameter int SOFT_W = 1
) (
  input  logic [SOFT_W-1:0] i_sample,
  input  logic              i_cw_bit,
  input  logic              i_erase,
  output logic [SOFT_W-1:0] o_dist
);

  localparam logic [SOFT_W-1:0] MAX_SAMPLE = '1;

  always_comb begin
    o_dist = i_sample;
    if (i_cw_bit) begin
      o_dist = MAX_SAMPLE - i_sample;
    end
    // Depunctured positions carry no information about either hypothesis.
    if (i_erase) begin
      o_dist = '0;
    end
  end

endmodule

// File: rtl/branch_metric_unit.sv
// Two-stage valid/ready branch-metric generator: s1 holds per-bit distances,
// s2 holds the per-codeword sums presented to the ACS array.
module branch_metric_unit
  import bmu_pkg::*;
#(
  parameter  int N_OUT  = 2,
  parameter  int SOFT_W = 1,
  parameter  int CNT_W  = 16,
  localparam int NUM_CW = 1 << N_OUT,
  localparam int BM_W   = bm_width(N_OUT, SOFT_W)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_OUT*SOFT_W-1:0]  i_data,
  input  logic [N_OUT-1:0]         i_erase,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_CW*BM_W-1:0]   o_bm,
  output logic [CNT_W-1:0]         o_sym_cnt
);

  localparam int DIST_W = NUM_CW * N_OUT * SOFT_W;

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; valid never waits on ready, and ready here depends only on
  // pipeline occupancy, i_ready and i_clr.
  logic               s1_adv;
  logic               s2_adv;
  logic               in_hs;
  logic               out_hs;

  logic [DIST_W-1:0]  dist_raw;
  logic [DIST_W-1:0]  dist_d, dist_q;
  logic               s1_v_d, s1_v_q;
  logic               valid_d, valid_q;
  logic [NUM_CW*BM_W-1:0] bm_sum;
  logic [NUM_CW*BM_W-1:0] bm_d, bm_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  // Distance for codeword c, bit k lives at slot (c*N_OUT + k).
  for (genvar c = 0; c < NUM_CW; c++) begin : g_cw
    for (genvar k = 0; k < N_OUT; k++) begin : g_bit
      bit_distance #(
        .SOFT_W (SOFT_W)
      ) u_bit_distance (
        .i_sample (i_data[k*SOFT_W +: SOFT_W]),
        .i_cw_bit (cw_bit(c, k)),
        .i_erase  (i_erase[k]),
        .o_dist   (dist_raw[(c*N_OUT + k)*SOFT_W +: SOFT_W])
      );
    end
  end

  always_comb begin
    s2_adv  = !valid_q || i_ready;
    s1_adv  = !s1_v_q || s2_adv;
    o_ready = s1_adv && !i_clr;
    in_hs   = i_valid && o_ready;
    out_hs  = valid_q && i_ready;
  end

  // Adder tree per codeword over the registered distances.
  always_comb begin
    bm_sum = '0;
    for (int c = 0; c < NUM_CW; c++) begin
      for (int k = 0; k < N_OUT; k++) begin
        bm_sum[c*BM_W +: BM_W] = bm_sum[c*BM_W +: BM_W]
                               + BM_W'(dist_q[(c*N_OUT + k)*SOFT_W +: SOFT_W]);
      end
    end
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    bm_d    = bm_q;
    if (i_clr) begin
      s1_v_d  = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      if (s1_adv) begin
        s1_v_d = in_hs;
      end
      if (s2_adv) begin
        valid_d = s1_v_q;
      end
      if (out_hs) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Data registers only move with a real transfer so idle inputs can be X.
    if (in_hs) begin
      dist_d = dist_raw;
    end
    if (s2_adv && s1_v_q && !i_clr) begin
      bm_d = bm_sum;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      dist_q  <= '0;
      bm_q    <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      bm_q    <= bm_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_bm      = bm_q;
  assign o_sym_cnt = cnt_q;

endmodule

// File: tb/tb_branch_metric_unit.sv
// Bench for branch_metric_unit: a hard-decision instance (4-bit counter) and a
// 3-bit soft instance, each with its own expected-result queue.
module tb_branch_metric_unit;

  logic        clk;
  logic        rst;

  logic        h_clr, h_valid, h_ready_o, h_ovalid, h_iready;
  logic [1:0]  h_data, h_erase;
  logic [7:0]  h_bm;
  logic [3:0]  h_cnt;

  logic        s_clr, s_valid, s_ready_o, s_ovalid, s_iready;
  logic [5:0]  s_data;
  logic [1:0]  s_erase;
  logic [15:0] s_bm;
  logic [15:0] s_cnt;

  logic [7:0]  h_exp_q[$];
  logic [15:0] s_exp_q[$];
  logic [3:0]  h_cnt_exp;
  logic [15:0] s_cnt_exp;

  int n_vec;
  int n_err;
  bit rand_done;
  logic [1:0] rd, re;
  logic [5:0] sd;

  branch_metric_unit #(.N_OUT(2), .SOFT_W(1), .CNT_W(4)) u_hard (
    .i_clk(clk), .i_rst(rst), .i_clr(h_clr), .i_valid(h_valid),
    .o_ready(h_ready_o), .i_data(h_data), .i_erase(h_erase),
    .o_valid(h_ovalid), .i_ready(h_iready), .o_bm(h_bm), .o_sym_cnt(h_cnt)
  );

  branch_metric_unit #(.N_OUT(2), .SOFT_W(3), .CNT_W(16)) u_soft (
    .i_clk(clk), .i_rst(rst), .i_clr(s_clr), .i_valid(s_valid),
    .o_ready(s_ready_o), .i_data(s_data), .i_erase(s_erase),
    .o_valid(s_ovalid), .i_ready(s_iready), .o_bm(s_bm), .o_sym_cnt(s_cnt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference metric for N_OUT=2 straight from the distance definition.
  function automatic logic [31:0] bm_model(input int soft_w, input int bmw, input int d, input int e);
    int maxv, s, sum;
    logic [31:0] r;
    maxv = (1 << soft_w) - 1;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      sum = 0;
      for (int k = 0; k < 2; k++) begin
        s = (d >> (k * soft_w)) & maxv;
        if (((e >> k) & 1) == 0) sum += (((c >> k) & 1) != 0) ? (maxv - s) : s;
      end
      r = r | (32'(sum) << (c * bmw));
    end
    return r;
  endfunction

  function automatic logic [7:0] h_model(input logic [1:0] d, input logic [1:0] e);
    logic [31:0] r;
    r = bm_model(1, 2, int'(d), int'(e));
    return r[7:0];
  endfunction

  function automatic logic [15:0] s_model(input logic [5:0] d, input logic [1:0] e);
    logic [31:0] r;
    r = bm_model(3, 4, int'(d), int'(e));
    return r[15:0];
  endfunction

  // Drivers: called at posedge+1, return at posedge+1 after the accepting edge.
  task automatic h_send(input logic [1:0] d, input logic [1:0] e, input logic [7:0] exp);
    int n = 0;
    h_valid = 1'b1; h_data = d; h_erase = e;
    @(negedge clk);
    while (!h_ready_o && n < 50) begin @(negedge clk); n++; end
    if (!h_ready_o) check("h_send_wait", h_ready_o, 1'b1);
    else h_exp_q.push_back(exp);
    @(posedge clk); #1;
    h_valid = 1'b0; h_data = 'x; h_erase = 'x;
  endtask

  task automatic s_send(input logic [5:0] d, input logic [1:0] e, input logic [15:0] exp);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_erase = e;
    @(negedge clk);
    while (!s_ready_o && n < 50) begin @(negedge clk); n++; end
    if (!s_ready_o) check("s_send_wait", s_ready_o, 1'b1);
    else s_exp_q.push_back(exp);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 'x; s_erase = 'x;
  endtask

  // Scoreboard monitors: compare at negedge when a transfer is about to occur.
  task automatic h_monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst || h_clr) begin
        h_exp_q.delete();
        h_cnt_exp = '0;
      end else if (h_ovalid && h_iready) begin
        check("h_cnt", h_cnt, h_cnt_exp);
        if (h_exp_q.size() == 0) check("h_extra", h_ovalid, 1'b0);
        else begin
          e = h_exp_q.pop_front();
          check("h_bm", h_bm, e);
        end
        h_cnt_exp++;
      end
    end
  endtask

  task automatic s_monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst || s_clr) begin
        s_exp_q.delete();
        s_cnt_exp = '0;
      end else if (s_ovalid && s_iready) begin
        check("s_cnt", s_cnt, s_cnt_exp);
        if (s_exp_q.size() == 0) check("s_extra", s_ovalid, 1'b0);
        else begin
          e = s_exp_q.pop_front();
          check("s_bm", s_bm, e);
        end
        s_cnt_exp++;
      end
    end
  endtask

  task automatic h_drain();
    int n = 0;
    while (h_exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("h_drain", h_exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic s_drain();
    int n = 0;
    while (s_exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("s_drain", s_exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic h_clr_pulse(input logic with_valid);
    h_clr = 1'b1; h_valid = with_valid; h_data = 2'b11; h_erase = 2'b00;
    @(negedge clk);
    check("clr_ready_low", h_ready_o, 1'b0);
    @(posedge clk); #1;
    h_clr = 1'b0; h_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    h_cnt_exp = '0; s_cnt_exp = '0;
    rst = 1'b1;
    h_clr = 1'b0; h_valid = 1'b0; h_data = '0; h_erase = '0; h_iready = 1'b1;
    s_clr = 1'b0; s_valid = 1'b0; s_data = '0; s_erase = '0; s_iready = 1'b1;
    fork
      h_monitor();
      s_monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_ovalid", h_ovalid, 1'b0);
    check("rst_cnt", h_cnt, 4'd0);
    check("rst_ready", h_ready_o, 1'b1);
    check("rst_bm", h_bm, 8'h00);
    check("rst_s_ovalid", s_ovalid, 1'b0);

    // Hard decision, latency and first count
    h_send(2'b10, 2'b00, 8'h49);
    check("lat_early", h_ovalid, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", h_ovalid, 1'b1);
    h_drain();
    check("cnt_after_one", h_cnt, 4'd1);

    // Erasures
    h_send(2'b10, 2'b10, 8'h44);
    h_send(2'b11, 2'b11, 8'h00);
    h_send(2'b01, 2'b00, 8'h61);
    h_drain();

    // Soft decision
    s_send(6'b110_001, 2'b00, 16'h72C7);
    s_send(6'b000_000, 2'b00, 16'hE770);
    s_send(6'b110_001, 2'b01, 16'h1166);
    for (int i = 0; i < 20; i++) begin
      sd = 6'($urandom_range(0, 63));
      re = 2'($urandom_range(0, 3));
      s_send(sd, re, s_model(sd, re));
    end
    s_drain();

    // Backpressure: stall three cycles after the first output
    h_clr_pulse(1'b0);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          rd = 2'($urandom_range(0, 3));
          h_send(rd, 2'b00, h_model(rd, 2'b00));
        end
      end
      begin
        int n = 0;
        while (!h_ovalid && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_first_valid", h_ovalid, 1'b1);
        h_iready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_valid", h_ovalid, 1'b1);
          check("stall_ready", h_ready_o, 1'b0);
          check("stall_bm", h_bm, h_exp_q[0]);
        end
        @(posedge clk); #1;
        h_iready = 1'b1;
      end
    join
    h_drain();
    check("bp_cnt", h_cnt, 4'd4);

    // Asynchronous reset with both stages full
    h_iready = 1'b0;
    h_send(2'b00, 2'b00, 8'h00);
    h_send(2'b11, 2'b00, 8'h00);
    check("full_valid", h_ovalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", h_ovalid, 1'b0);
    check("rst_async_cnt", h_cnt, 4'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    h_iready = 1'b1;
    check("post_rst_ready", h_ready_o, 1'b1);
    h_send(2'b01, 2'b00, 8'h61);
    check("post_rst_early", h_ovalid, 1'b0);
    @(posedge clk); #1;
    check("post_rst_valid", h_ovalid, 1'b1);
    h_drain();

    // Clear drops an in-flight symbol and a concurrent offer
    h_send(2'b10, 2'b00, 8'h49);
    h_clr_pulse(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_no_output", h_ovalid, 1'b0);
    end
    check("clr_cnt", h_cnt, 4'd0);
    @(posedge clk); #1;

    // Counter wrap at 4 bits
    for (int i = 0; i < 15; i++) begin
      rd = 2'($urandom_range(0, 3));
      h_send(rd, 2'b00, h_model(rd, 2'b00));
    end
    h_drain();
    check("wrap_15", h_cnt, 4'd15);
    h_send(2'b11, 2'b00, h_model(2'b11, 2'b00));
    h_drain();
    check("wrap_0", h_cnt, 4'd0);
    h_send(2'b00, 2'b01, h_model(2'b00, 2'b01));
    h_drain();
    check("wrap_1", h_cnt, 4'd1);

    // Random data, erasures and downstream readiness
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          rd = 2'($urandom_range(0, 3));
          re = 2'($urandom_range(0, 3));
          h_send(rd, re, h_model(rd, re));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          h_iready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    h_iready = 1'b1;
    h_drain();
    check("h_left", h_exp_q.size(), 0);
    check("s_left", s_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
